// File: rtl/aes_dec_controller.sv
// Sequencing controller for the byte-serial AES-128 decryption datapath (load, then 10 rounds with inverse key schedule).
// Latency: 250 cycles from the start-accept edge to the return to IDLE (20 load + 10 x 23 round cycles).
// Backpressure: none; start is sampled only in IDLE, and busy stays high for the whole run. Optional abort input under AES_DEC_CTRL_ABORT_EN.
module aes_dec_controller #(
   parameter int          FinalRoundNumber = 10,
   parameter logic [7:0]  RconInit         = 8'h36
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
`ifdef AES_DEC_CTRL_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       KeyScheduleRegisterEN,
   output logic       ShowRcon,
   output logic       DoInvSR,
   output logic       DoInvMC,
   output logic       state_reg_hold,
   output logic       key_reg_hold,
   output logic       DoKeySbox,
   output logic       JustFirstColShift,
   output logic       Done,
   output logic       CorrectPlaintext,
   output logic       output_sel,
   output logic [1:0] KeyIn_sel,
   output logic [1:0] SboxIn_sel,
   output logic [7:0] Rcon
);

   typedef enum logic [1:0] {IDLE, LOAD, ROUND} state_t;

   state_t     state_q, state_d;
   logic [3:0] RoundCounter, round_d;
   logic [4:0] PerRoundCounter, per_d;
   logic [7:0] Rcon_Reg, rcon_d;
   logic       abort_w;
   logic       last_round;
   logic [7:0] rcon_xor;
   logic [7:0] rcon_inv_xtime;

`ifdef AES_DEC_CTRL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign last_round     = (RoundCounter == 4'(FinalRoundNumber));
   // Inverse of xtime: undo the conditional 0x1B reduction, then shift right.
   assign rcon_xor       = Rcon_Reg ^ 8'h1B;
   assign rcon_inv_xtime = Rcon_Reg[0] ? {1'b1, rcon_xor[7:1]} : {1'b0, Rcon_Reg[7:1]};
   assign Rcon           = Rcon_Reg;

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         RoundCounter    <= 4'd0;
         PerRoundCounter <= 5'd0;
         Rcon_Reg        <= RconInit;
      end else begin
         state_q         <= state_d;
         RoundCounter    <= round_d;
         PerRoundCounter <= per_d;
         Rcon_Reg        <= rcon_d;
      end
   end

   // Next-state, counter stepping and per-count datapath strobes.
   always_comb begin
      state_d               = state_q;
      round_d               = RoundCounter;
      per_d                 = PerRoundCounter;
      rcon_d                = Rcon_Reg;
      busy                  = 1'b0;
      KeyScheduleRegisterEN = 1'b0;
      ShowRcon              = 1'b0;
      DoInvSR               = 1'b0;
      DoInvMC               = 1'b0;
      state_reg_hold        = 1'b1;
      key_reg_hold          = 1'b1;
      DoKeySbox             = 1'b0;
      JustFirstColShift     = 1'b0;
      Done                  = 1'b0;
      CorrectPlaintext      = 1'b0;
      output_sel            = 1'b1;
      KeyIn_sel             = 2'd0;
      SboxIn_sel            = 2'd0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               per_d   = 5'd0;
            end
         end

         LOAD: begin
            busy       = 1'b1;
            SboxIn_sel = (PerRoundCounter < 5'd16) ? 2'd0 : 2'd1;
            DoKeySbox  = (PerRoundCounter >= 5'd16);
            if (PerRoundCounter == 5'd19) begin
               state_d = ROUND;
               round_d = 4'd1;
               per_d   = 5'd0;
            end else begin
               per_d = PerRoundCounter + 5'd1;
            end
         end

         ROUND: begin
            busy                  = 1'b1;
            key_reg_hold          = (PerRoundCounter > 5'd1);
            DoInvSR               = (PerRoundCounter == 5'd1);
            state_reg_hold        = (PerRoundCounter != 5'd2);
            JustFirstColShift     = (PerRoundCounter == 5'd2);
            KeyScheduleRegisterEN = (PerRoundCounter >= 5'd2) && (PerRoundCounter <= 5'd5);
            ShowRcon              = (PerRoundCounter == 5'd3);
            DoKeySbox             = (PerRoundCounter >= 5'd19);

            // Round 1 still takes the loaded last-round key for its first three bytes.
            if ((PerRoundCounter >= 5'd3) && (PerRoundCounter <= 5'd6))
               KeyIn_sel = 2'd1;
            else if ((RoundCounter == 4'd1) && (PerRoundCounter <= 5'd2))
               KeyIn_sel = 2'd0;
            else
               KeyIn_sel = 2'd2;

            if ((PerRoundCounter <= 5'd2) || (PerRoundCounter >= 5'd19))
               SboxIn_sel = 2'd1;
            else if (PerRoundCounter <= 5'd6)
               SboxIn_sel = 2'd2;
            else
               SboxIn_sel = 2'd3;

            // The final round skips InvMixColumns and streams out plaintext instead.
            if (!last_round) begin
               DoInvMC = (PerRoundCounter < 5'd16) && (PerRoundCounter[1:0] == 2'd3);
            end else begin
               output_sel       = !((PerRoundCounter >= 5'd3) && (PerRoundCounter <= 5'd6));
               Done             = (PerRoundCounter >= 5'd3) && (PerRoundCounter <= 5'd18) && !abort_w;
               CorrectPlaintext = (PerRoundCounter == 5'd4) && !abort_w;
            end

            if (PerRoundCounter == 5'd22) begin
               if (last_round) begin
                  state_d = IDLE;
                  round_d = 4'd0;
                  per_d   = 5'd0;
                  rcon_d  = RconInit;
               end else begin
                  round_d = RoundCounter + 4'd1;
                  per_d   = 5'd0;
                  rcon_d  = rcon_inv_xtime;
               end
            end else begin
               per_d = PerRoundCounter + 5'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides any round-end transition; it is meaningless in IDLE.
      if (abort_w && (state_q != IDLE)) begin
         state_d = IDLE;
         round_d = 4'd0;
         per_d   = 5'd0;
         rcon_d  = RconInit;
      end
   end

endmodule

// File: tb/tb_aes_dec_controller.sv
// Bench for aes_dec_controller: a run-position model (linear cycle index -> round/count) checked every cycle,
// plus literal expectations on run length, strobe counts, Rcon sequence and final-round output window.
// Define AES_DEC_CTRL_ABORT_EN to also exercise the abort input.
module tb_aes_dec_controller;

   localparam int RUN_CYC = 20 + 10 * 23;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy, KeyScheduleRegisterEN, ShowRcon, DoInvSR, DoInvMC;
   logic       state_reg_hold, key_reg_hold, DoKeySbox, JustFirstColShift;
   logic       Done, CorrectPlaintext, output_sel;
   logic [1:0] KeyIn_sel, SboxIn_sel;
   logic [7:0] Rcon;

   aes_dec_controller dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .start                 (start),
`ifdef AES_DEC_CTRL_ABORT_EN
      .abort                 (abort),
`endif
      .busy                  (busy),
      .KeyScheduleRegisterEN (KeyScheduleRegisterEN),
      .ShowRcon              (ShowRcon),
      .DoInvSR               (DoInvSR),
      .DoInvMC               (DoInvMC),
      .state_reg_hold        (state_reg_hold),
      .key_reg_hold          (key_reg_hold),
      .DoKeySbox             (DoKeySbox),
      .JustFirstColShift     (JustFirstColShift),
      .Done                  (Done),
      .CorrectPlaintext      (CorrectPlaintext),
      .output_sel            (output_sel),
      .KeyIn_sel             (KeyIn_sel),
      .SboxIn_sel            (SboxIn_sel),
      .Rcon                  (Rcon)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: active flag plus a linear cycle index within the run.
   bit m_act = 1'b0;
   int m_k = 0;
   logic [7:0] rcon_tab [10] = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   // Running totals sampled once per cycle.
   int tot_busy = 0, tot_invmc = 0, tot_done = 0, tot_cp = 0, tot_osel0 = 0, tot_dks = 0;
   int rises = 0, gap_len = 0, last_gap = -1, done_idx = 0, cp_at = -1;
   bit prev_busy = 1'b0;
   logic [7:0] rcon_log [$];

   function automatic logic [23:0] model_out(bit act, int k, bit ab);
      logic busy_e = 0, ksen = 0, shr = 0, isr = 0, imc = 0, srh = 1, krh = 1, dks = 0, jf = 0;
      logic dn = 0, cp = 0, osel = 1;
      logic [1:0] kin = 0, sbx = 0;
      logic [7:0] rc = 8'h36;
      int r, c;
      if (act) begin
         busy_e = 1;
         if (k < 20) begin
            sbx = (k < 16) ? 2'd0 : 2'd1;
            dks = (k >= 16);
         end else begin
            r   = (k - 20) / 23 + 1;
            c   = (k - 20) % 23;
            rc  = rcon_tab[r-1];
            krh = !(c == 0 || c == 1);
            isr = (c == 1);
            srh = (c != 2);
            jf  = (c == 2);
            ksen = (c >= 2 && c <= 5);
            shr = (c == 3);
            dks = (c >= 19);
            kin = 2'd2;
            if (r == 1 && c <= 2) kin = 2'd0;
            if (c >= 3 && c <= 6) kin = 2'd1;
            sbx = 2'd3;
            if (c <= 2 || c >= 19) sbx = 2'd1;
            else if (c <= 6) sbx = 2'd2;
            imc = (r != 10) && (c == 3 || c == 7 || c == 11 || c == 15);
            if (r == 10) begin
               osel = !(c >= 3 && c <= 6);
               dn   = (c >= 3 && c <= 18) && !ab;
               cp   = (c == 4) && !ab;
            end
         end
      end
      return {busy_e, ksen, shr, isr, imc, srh, krh, dks, jf, dn, cp, osel, kin, sbx, rc};
   endfunction

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One clock: advance the model on the edge, then compare and collect statistics.
   task automatic tick();
      logic [23:0] e, a;
      @(posedge clk);
      if (!rst_n) begin
         m_act = 1'b0; m_k = 0;
      end else if (!m_act) begin
         if (start) begin m_act = 1'b1; m_k = 0; end
      end else if (abort) begin
         m_act = 1'b0;
      end else if (m_k == RUN_CYC - 1) begin
         m_act = 1'b0;
      end else begin
         m_k++;
      end
      #1;
      e = model_out(m_act, m_k, abort);
      a = {busy, KeyScheduleRegisterEN, ShowRcon, DoInvSR, DoInvMC, state_reg_hold, key_reg_hold,
           DoKeySbox, JustFirstColShift, Done, CorrectPlaintext, output_sel, KeyIn_sel, SboxIn_sel, Rcon};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL cycle_outputs t=%0t got=%06h expected=%06h", $time, a, e);
      end
      tot_busy  += int'(busy);
      tot_invmc += int'(DoInvMC);
      tot_done  += int'(Done);
      tot_cp    += int'(CorrectPlaintext);
      tot_osel0 += int'(!output_sel);
      tot_dks   += int'(DoKeySbox);
      if (ShowRcon) rcon_log.push_back(Rcon);
      if (busy) begin
         if (!prev_busy) begin rises++; last_gap = gap_len; end
         gap_len = 0;
      end else begin
         gap_len++;
      end
      prev_busy = busy;
      if (!busy) done_idx = 0;
      if (Done) begin
         if (CorrectPlaintext) cp_at = done_idx;
         done_idx++;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin tick(); n++; end
      check({name, "_reaches_idle"}, int'(busy), 0);
   endtask

   initial begin
      int b_busy, b_imc, b_done, b_cp, b_osel, b_dks, b_log, b_rises;

      // Reset for two edges, then idle with start low.
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("idle_busy", int'(busy), 0);
      check("idle_rcon", int'(Rcon), 'h36);
      check("idle_keyin", int'(KeyIn_sel), 0);
      check("idle_sboxin", int'(SboxIn_sel), 0);
      check("idle_holds", int'({state_reg_hold, key_reg_hold, output_sel}), 7);

      // Full run from a one-cycle start pulse.
      b_busy = tot_busy; b_imc = tot_invmc; b_done = tot_done; b_cp = tot_cp;
      b_osel = tot_osel0; b_dks = tot_dks; b_log = rcon_log.size();
      start = 1'b1; tick(); start = 1'b0;
      wait_idle("full_run", 400);
      check("run_busy_cycles", tot_busy - b_busy, 250);
      check("run_invmc_pulses", tot_invmc - b_imc, 36);
      check("run_done_cycles", tot_done - b_done, 16);
      check("run_cp_pulses", tot_cp - b_cp, 1);
      check("run_cp_on_second_done", cp_at, 1);
      check("run_output_sel_low", tot_osel0 - b_osel, 4);
      check("run_keysbox_cycles", tot_dks - b_dks, 44);
      check("run_rcon_samples", rcon_log.size() - b_log, 10);
      if (rcon_log.size() - b_log == 10)
         for (int i = 0; i < 10; i++) check($sformatf("rcon_round%0d", i + 1), int'(rcon_log[b_log + i]), int'(rcon_tab[i]));
      repeat (3) tick();

      // Start held high through one run plus one cycle: two back-to-back runs.
      b_busy = tot_busy; b_rises = rises;
      start = 1'b1; tick();
      repeat (251) tick();
      start = 1'b0;
      wait_idle("back_to_back", 400);
      check("b2b_busy_cycles", tot_busy - b_busy, 500);
      check("b2b_runs", rises - b_rises, 2);
      check("b2b_gap_cycles", last_gap, 1);
      repeat (3) tick();

      // Synchronous reset in round 5 count 10.
      b_done = tot_done;
      start = 1'b1; tick(); start = 1'b0;
      repeat (122) tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("midreset_busy", int'(busy), 0);
      check("midreset_rcon", int'(Rcon), 'h36);
      repeat (5) tick();
      check("midreset_no_done", tot_done - b_done, 0);

`ifdef AES_DEC_CTRL_ABORT_EN
      // Abort at round 10 count 2, then a normal run.
      b_done = tot_done; b_cp = tot_cp;
      start = 1'b1; tick(); start = 1'b0;
      repeat (229) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_rcon", int'(Rcon), 'h36);
      repeat (5) tick();
      check("abort_no_done", tot_done - b_done, 0);
      check("abort_no_cp", tot_cp - b_cp, 0);
      abort = 1'b1; repeat (2) tick(); abort = 1'b0;
      check("abort_idle_noeffect", int'(busy), 0);
      b_busy = tot_busy; b_done = tot_done;
      start = 1'b1; tick(); start = 1'b0;
      wait_idle("after_abort", 400);
      check("after_abort_busy_cycles", tot_busy - b_busy, 250);
      check("after_abort_done_cycles", tot_done - b_done, 16);
`endif

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
